// File: rtl/regfile_wb.sv
// Write-back register file: 2 registered read ports, 1 write port, r0 hardwired to zero, zeroing sweep after reset.
// Latency: reads 1 cycle, writes visible next cycle; define REGFILE_BYPASS_EN to forward a same-cycle write to a matching read.
// Backpressure: none; busy is high during reset and the 2**ADDR_W-cycle clearing sweep, and writes arriving then are dropped.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                busy_nxt;
    logic [DATA_W-1:0]   rdata1_nxt, rdata2_nxt;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            rdata1 <= rdata1_nxt;
            rdata2 <= rdata2_nxt;
        end
    end

    // Array has no reset of its own; the sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        rdata1_nxt = '0;
        rdata2_nxt = '0;
        mem_we     = 1'b0;
        mem_waddr  = waddr;
        mem_wdata  = wdata;

        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                cnt_nxt   = cnt + ADDR_W'(1);
                busy_nxt  = 1'b1;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = RUN;
                    busy_nxt  = 1'b0;
                end
            end
            RUN: begin
                mem_we   = we && (waddr != '0);
                busy_nxt = 1'b0;
                if (raddr1 != '0) begin
                    rdata1_nxt = mem[raddr1];
                end
                if (raddr2 != '0) begin
                    rdata2_nxt = mem[raddr2];
                end
`ifdef REGFILE_BYPASS_EN
                // mem_we already excludes index 0, so r0 is never forwarded.
                if (mem_we && (waddr == raddr1)) begin
                    rdata1_nxt = wdata;
                end
                if (mem_we && (waddr == raddr2)) begin
                    rdata2_nxt = wdata;
                end
`endif
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus pushes expected outputs into a queue, a monitor compares them after each edge.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .busy   (busy)
    );

    // m[0] checks rdata1, m[1] rdata2, m[2] busy
    typedef struct {
        logic [2:0]  m;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus cycle: drive on the falling edge, queue what the outputs must be after the next rising edge.
    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [2:0] m, input logic [31:0] e1, input logic [31:0] e2,
                        input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        e.m = m; e.e1 = e1; e.e2 = e2; e.eb = eb; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // 32 sweep cycles with rst low; outputs stay 0, busy falls on the last one.
    task automatic sweep(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input string nm);
        for (int k = 1; k <= 32; k++) begin
            step(1'b0, w, wa, wd, a1, a2, 3'b111, 32'h0, 32'h0, (k < 32) ? 1'b1 : 1'b0, nm);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.m[0]) begin
                    n_chk++;
                    if (rdata1 !== e.e1) begin
                        n_fail++;
                        $display("FAIL %s rdata1 got %h expected %h", e.nm, rdata1, e.e1);
                    end
                end
                if (e.m[1]) begin
                    n_chk++;
                    if (rdata2 !== e.e2) begin
                        n_fail++;
                        $display("FAIL %s rdata2 got %h expected %h", e.nm, rdata2, e.e2);
                    end
                end
                if (e.m[2]) begin
                    n_chk++;
                    if (busy !== e.eb) begin
                        n_fail++;
                        $display("FAIL %s busy got %b expected %b", e.nm, busy, e.eb);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] hz;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 3'b111, 32'h0, 32'h0, 1'b1, "reset");
        end
        // Writes attempted during the sweep must be dropped.
        sweep(1'b1, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd3, "sweep1");

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 3'b111, 32'h0, 32'h0, 1'b0, "clear_read");
        end

        step(1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd0, 5'd0, 3'b111, 32'h0, 32'h0, 1'b0, "wr31");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, 3'b011, 32'hDEAD_BEEF, 32'h0, 1'b0, "rd31");
        step(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 3'b011, 32'h0, 32'h0, 1'b0, "wr0_same");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 3'b011, 32'h0, 32'h0, 1'b0, "rd0");

        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0, 3'b000, 32'h0, 32'h0, 1'b0, "wr5");
`ifdef REGFILE_BYPASS_EN
        hz = 32'h2222_2222;
`else
        hz = 32'h1111_1111;
`endif
        step(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd31, 5'd5, 3'b011, 32'hDEAD_BEEF, hz, 1'b0, "hazard5");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 3'b011, 32'h2222_2222, 32'h2222_2222, 1'b0, "rd5_next");

        step(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd0, 5'd0, 3'b000, 32'h0, 32'h0, 1'b0, "wr9");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 3'b011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, "dual9");

        // Reset from RUN, pulse again 10 cycles into the sweep, then a full sweep must follow.
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 3'b111, 32'h0, 32'h0, 1'b1, "rst_run");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 3'b111, 32'h0, 32'h0, 1'b1, "part_sweep");
        end
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 3'b111, 32'h0, 32'h0, 1'b1, "rst_mid");
        sweep(1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "sweep2");

        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd9, 3'b111, 32'h0, 32'h0, 1'b0, "post_rd_a");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 3'b111, 32'h0, 32'h0, 1'b0, "post_rd_b");
        step(1'b0, 1'b1, 5'd12, 32'h0BAD_F00D, 5'd0, 5'd0, 3'b000, 32'h0, 32'h0, 1'b0, "wr12");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 3'b011, 32'h0BAD_F00D, 32'h0, 1'b0, "rd12");

        repeat (4) @(posedge clk);
        #3;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue entries left %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Synchronous-read general-purpose register file that terminates the write-back destination path of the MIPS datapath: it consumes the 5-bit destination index (rd, rt or link register 31) and the write-back data, and serves two registered read ports to the decode stage. After reset it runs a self-clearing sweep that zeroes all entries, one per cycle, and flags itself busy until the sweep ends. Register 0 reads as zero and ignores writes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; depth = 2**ADDR_W (32)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- we  input  1  write enable from write-back stage
- waddr  input  ADDR_W  destination index (rd / rt / 31)
- wdata  input  DATA_W  write-back data
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  DATA_W  registered read data, port 1
- rdata2  output  DATA_W  registered read data, port 2
- busy  output  1  high while reset or clearing sweep is active

## Operation
- States: CLEAR, RUN.
- rst high at a clock edge: state <= CLEAR, sweep counter <= 0, busy <= 1, rdata1/rdata2 <= 0. Array contents are not touched in that cycle.
- CLEAR, rst low: each cycle writes 0 to entry[counter], counter increments. After writing entry 31 (counter wraps 31->0), state <= RUN, busy <= 0 on that same edge.
- CLEAR: we/waddr/wdata ignored (writes dropped, not queued); rdata1/rdata2 forced to 0 each cycle.
- RUN: if we && waddr != 0, entry[waddr] <= wdata. we with waddr == 0 is a no-op.
- RUN: rdata1 <= (raddr1 == 0) ? 0 : entry[raddr1]; same for port 2 with raddr2.
- Same-cycle write and read of one index: see Configuration.
- Both read ports may address the same index; both return identical data.
- rst asserted mid-sweep or mid-operation: sweep restarts from entry 0 on the following cycle with rst low; the full 32-cycle sweep is always completed.

## Timing
- Read latency: 1 cycle (address sampled at edge N, data valid after edge N).
- Write latency: 1 cycle; written value is visible to a read issued on the next cycle.
- Reset values: rdata1 = 0, rdata2 = 0, busy = 1.
- Sweep length: exactly 32 cycles of rst low; busy falls at the edge that clears entry 31, so first accepted write is at cycle 33 after rst deasserts.
- No combinational path from inputs to outputs.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if we && waddr != 0 && waddr == raddrN, rdataN <= wdata (write-through forwarding; the decode stage sees the value being written back in the same cycle).
- Undefined: read-before-write; rdataN returns the entry's prior contents, and the new value appears only for reads issued one cycle later.
- Writes to index 0 are never forwarded in either build.

## Test plan
- Reset then sweep: rst high 3 cycles, release; busy stays 1 for 32 cycles, falls on the 32nd; reads of all 32 indices afterwards return 0x00000000.
- Write/read: write 0xDEADBEEF to 31, next cycle read raddr1=31 -> rdata1 = 0xDEADBEEF one cycle later; write 0x12345678 to 0, read 0 -> 0x00000000.
- Same-cycle hazard: entry 5 = 0x11111111; cycle with we=1, waddr=5, wdata=0x22222222, raddr2=5 -> rdata2 = 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; next-cycle read returns 0x22222222 in both builds.
- Writes during sweep: we=1, waddr=7, wdata=0xFFFFFFFF asserted while busy=1 -> after sweep, entry 7 reads 0x00000000; rdata1/rdata2 held at 0 throughout sweep.
- Reset mid-sweep: rst pulsed at sweep cycle 10 -> busy remains 1 for a further full 32 cycles after release; all entries read 0.
- Dual-port same index: entry 9 = 0xA5A5A5A5, raddr1 = raddr2 = 9 -> both outputs 0xA5A5A5A5 one cycle later.
